frame_serial_tx: RTL

//  Transmit end of the lab board's single-wire serial link. Takes a DATA_W-bit parallel word
//  (switch/IBUF inputs), frames it and shifts it out LSB-first on one output pad.

---
 rtl/frame_serial_tx.sv | 112 +++++++++++
 1 files changed

// File: rtl/frame_serial_tx.sv
// frame_serial_tx: frames a DATA_W-bit word as start/data/[parity]/stop and shifts it out LSB-first on a registered tx pad.
// Optional even-parity bit is enabled by defining PARITY_EN.
module frame_serial_tx #(
    parameter int DATA_W   = 2,
    parameter int BAUD_DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              load,
    output logic              ready,
    output logic              tx,
    output logic              busy
);
    localparam int CW = BAUD_DIV > 1 ? $clog2(BAUD_DIV) : 1;
    localparam int IW = DATA_W > 1 ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              tx_q, tx_d;
    logic              wrap;
`ifdef PARITY_EN
    logic              par_q, par_d;
`endif

    assign wrap  = cnt_q == CW'(BAUD_DIV - 1);
    assign ready = state_q == IDLE;
    assign busy  = ~ready;
    assign tx    = tx_q;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        idx_d   = idx_q;
        cnt_d   = wrap ? '0 : cnt_q + CW'(1);
`ifdef PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (load) begin
                    state_d = START;
                    shreg_d = data_in;
                    idx_d   = '0;
`ifdef PARITY_EN
                    par_d   = ^data_in;
`endif
                end
            end
            START: if (wrap) state_d = DATA;
            DATA: if (wrap) begin
                if (idx_q == IW'(DATA_W - 1)) begin
`ifdef PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end else begin
                    shreg_d = shreg_q >> 1;
                    idx_d   = idx_q + IW'(1);
                end
            end
`ifdef PARITY_EN
            PARITY: if (wrap) state_d = STOP;
`endif
            STOP: if (wrap) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // tx is a function of the next state so the pad flop changes together with the state
`ifdef PARITY_EN
        tx_d = (state_d == START) ? 1'b0 : (state_d == DATA) ? shreg_d[0] :
               (state_d == PARITY) ? par_d : 1'b1;
`else
        tx_d = (state_d == START) ? 1'b0 : (state_d == DATA) ? shreg_d[0] : 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            tx_q    <= 1'b1;
`ifdef PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
`ifdef PARITY_EN
            par_q   <= par_d;
`endif
        end
    end
endmodule
